// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with a direct-mapped branch target buffer.
// Each entry holds a 2-bit bimodal counter, a tag and a target; the table is trained from execute-stage resolutions.
module fetch_pc_unit #(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        stall,
  input  logic        fail_predictE,
  input  logic [12:0] nextpc,
  input  logic        update_validE,
  input  logic [12:0] update_pcE,
  input  logic        update_takenE,
  input  logic [12:0] update_targetE,
  output logic [12:0] pcF,
  output logic        pred_takenF,
  output logic        cannot_predictF
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 13 - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [12:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t  r_btb [BTB_ENTRIES];
  logic [12:0] r_pc;

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  btb_entry_t       w_f_entry;
  logic             w_f_hit;
  logic [12:0]      w_pred_next;

  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  btb_entry_t       w_u_entry;
  logic             w_u_hit;

  // Lookup reads the registered table only, so an update in this cycle is seen next cycle.
  assign w_f_idx   = r_pc[IDX_W+1:2];
  assign w_f_tag   = r_pc[12:IDX_W+2];
  assign w_f_entry = r_btb[w_f_idx];
  assign w_f_hit   = w_f_entry.valid && (w_f_entry.tag == w_f_tag);

  assign pcF             = r_pc;
  assign pred_takenF     = w_f_hit && w_f_entry.ctr[1];
  assign cannot_predictF = !w_f_hit;
  assign w_pred_next     = pred_takenF ? w_f_entry.target : r_pc + 13'd4;

  assign w_u_idx   = update_pcE[IDX_W+1:2];
  assign w_u_tag   = update_pcE[12:IDX_W+2];
  assign w_u_entry = r_btb[w_u_idx];
  assign w_u_hit   = w_u_entry.valid && (w_u_entry.tag == w_u_tag);

  // Redirect outranks stall so a misprediction is never dropped.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_pc <= 13'd0;
    end else if (fail_predictE) begin
      r_pc <= nextpc;
    end else if (!stall) begin
      r_pc <= w_pred_next;
    end
  end

  // NOTE: the table is held in flops and every entry is reset, because the counters must
  // restart at weakly-not-taken and stale valid bits would produce phantom predictions.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i] <= '{valid: 1'b0, tag: '0, target: 13'd0, ctr: 2'b01};
      end
    end else if (update_validE) begin
      if (w_u_hit) begin
        if (update_takenE) begin
          r_btb[w_u_idx].target <= update_targetE;
          if (w_u_entry.ctr != 2'b11) r_btb[w_u_idx].ctr <= w_u_entry.ctr + 2'd1;
        end else if (w_u_entry.ctr != 2'b00) begin
          r_btb[w_u_idx].ctr <= w_u_entry.ctr - 2'd1;
        end
      end else if (update_takenE) begin
        r_btb[w_u_idx] <= '{valid: 1'b1, tag: w_u_tag, target: update_targetE, ctr: 2'b10};
      end
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL: parameter BTB_ENTRIES, default 16, number of direct-mapped predictor entries (fixed at 16 for this revision).
REQ-002 SHALL: CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 SHALL: NRST  input  1  reset; synchronous, active-low.
REQ-004 SHALL: stall  input  1  hold fetch PC this cycle.
REQ-005 SHALL: fail_predictE  input  1  execute-stage misprediction; redirect fetch.
REQ-006 SHALL: nextpc  input  13  correct PC to fetch after a misprediction.
REQ-007 SHALL: update_validE  input  1  execute stage resolves a branch/jump this cycle.
REQ-008 SHALL: update_pcE  input  13  PC of the resolved instruction.
REQ-009 SHALL: update_takenE  input  1  resolved outcome (1 = taken).
REQ-010 SHALL: update_targetE  input  13  resolved target PC.
REQ-011 SHALL: pcF  output  13  current fetch PC (registered).
REQ-012 SHALL: pred_takenF  output  1  predictor says taken for pcF (combinational from pcF and table state).
REQ-013 SHALL: cannot_predictF  output  1  no valid predictor entry matches pcF (combinational).

Function
REQ-014 SHALL: pcF be a byte address, sequential step +4, 13-bit modulo arithmetic (13'h1FFC + 4 = 13'h0000, no carry out).
REQ-015 SHALL: entry index = pc[5:2], tag = pc[12:6] (7 bits); each entry holds valid, tag, 13-bit target, 2-bit saturating counter.
REQ-016 SHALL: hit = valid & tag match for pcF; cannot_predictF = !hit; pred_takenF = hit & counter[1].
REQ-017 SHALL: predicted next PC = stored target when pred_takenF, else pcF + 4.
REQ-018 SHALL: pcF next-state priority: NRST low -> 0; else fail_predictE -> nextpc; else stall -> hold pcF; else predicted next PC.
REQ-019 SHALL: fail_predictE override stall in the same cycle (redirect is never lost).
REQ-020 SHALL: on update_validE with hit at update_pcE: counter +1 saturating at 2'b11 if taken, -1 saturating at 2'b00 if not taken; target overwritten with update_targetE when taken.
REQ-021 SHALL: on update_validE with miss and taken: allocate/replace entry: valid=1, tag from update_pcE, target=update_targetE, counter=2'b10.
REQ-022 SHALL: on update_validE with miss and not taken: table unchanged.
REQ-023 SHALL: table update occur regardless of stall and fail_predictE (update takes effect at the clock edge).
REQ-024 SHALL: lookup for pcF in the same cycle as an update to the same index use pre-update contents (read-before-write); new contents visible the following cycle.
REQ-025 SHALL: update_pcE/update_takenE/update_targetE be ignored when update_validE = 0.
REQ-026 SHALL: no outputs depend combinationally on stall, fail_predictE or update_* inputs.

Reset
REQ-027 SHALL: while NRST = 0 at a posedge: pcF <= 0, all valid bits <= 0, all counters <= 2'b01, tags/targets <= 0.
REQ-028 SHALL: after reset pred_takenF = 0 and cannot_predictF = 1 for every pcF until an entry is allocated.
REQ-029 SHALL: reset asserted mid-operation override any concurrent fail_predictE, stall or update in that cycle.
REQ-030 SHALL: updates in the reset cycle be discarded.

Verification
REQ-031 SHALL: reset, then 4 free-running cycles -> pcF = 0,4,8,12; cannot_predictF = 1, pred_takenF = 0 throughout.
REQ-032 SHALL: update_validE=1, update_pcE=13'h0010, taken=1, target=13'h0100; later pcF reaches 13'h0010 -> pred_takenF=1, cannot_predictF=0, next pcF = 13'h0100.
REQ-033 SHALL: from the REQ-032 state, two not-taken updates for 13'h0010 -> counter 10->01->00; next visit to 13'h0010 gives pred_takenF=0, next pcF = 13'h0014.
REQ-034 SHALL: stall=1 and fail_predictE=1 with nextpc=13'h0A00 in the same cycle -> next pcF = 13'h0A00; stall alone for 3 cycles -> pcF held constant.
REQ-035 SHALL: pcF = 13'h1FFC, no hit, no stall -> next pcF = 13'h0000.
REQ-036 SHALL: taken update for 13'h0050 (index 4) then taken update for 13'h1050 (same index, different tag) -> 13'h0050 now misses (cannot_predictF=1), 13'h1050 hits with counter 2'b10.
